// File: rtl/mod_pkt_fsm_sequencer.sv
// Packet command sequencer: READ bursts generated locally, WRITE bursts forwarded with one
// cycle of latency, idle timeout inside WRITE bursts, and a saturating error-entry counter.
typedef struct packed {
    logic [3:0] id;
    logic [7:0] data;
} my_packet_t;

typedef enum logic [1:0] {
    STATE_IDLE  = 2'd0,
    STATE_READ  = 2'd1,
    STATE_WRITE = 2'd2,
    STATE_ERROR = 2'd3
} fsm_state_e;

module mod_pkt_fsm_sequencer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       in_clk,
    input  logic       in_rst,
    input  logic       in_valid,
    output logic       out_ready,
    input  my_packet_t in_packet,
    input  logic       in_clear,
    output fsm_state_e out_state,
    output my_packet_t out_packet,
    output logic       out_pkt_valid,
    output logic [3:0] out_beats_left,
    output logic [7:0] out_err_count
);

    localparam logic [7:0] IdleLast = 8'(TIMEOUT - 1);

    fsm_state_e state_q, state_d;
    my_packet_t pkt_q, pkt_d;
    logic       pkt_valid_q, pkt_valid_d;
    logic [3:0] beats_q, beats_d;
    logic [7:0] idle_q, idle_d;
    logic [7:0] err_q, err_d;
    logic       transfer;
    logic       enter_err;
    logic [3:0] next_idx;

    assign out_ready = (state_q == STATE_IDLE) || (state_q == STATE_WRITE);
    assign transfer  = in_valid && out_ready;
    // During READ the low nibble of the outgoing packet doubles as the beat index.
    assign next_idx  = pkt_q.data[3:0] + 4'd1;

    always_comb begin
        state_d     = state_q;
        pkt_d       = pkt_q;
        pkt_valid_d = 1'b0;
        beats_d     = beats_q;
        idle_d      = idle_q;
        err_d       = err_q;
        enter_err   = 1'b0;

        unique case (state_q)
            STATE_IDLE: begin
                idle_d = 8'd0;
                if (transfer) begin
                    if (in_packet.id == 4'hA) begin
                        state_d     = STATE_READ;
                        beats_d     = in_packet.data[3:0];
                        pkt_d       = '{id: 4'hA, data: 8'h00};
                        pkt_valid_d = 1'b1;
                    end else if (in_packet.id == 4'hB) begin
                        state_d = STATE_WRITE;
                        beats_d = in_packet.data[3:0];
                    end else begin
                        enter_err = 1'b1;
                    end
                end
            end
            STATE_READ: begin
                if (beats_q == 4'd0) begin
                    state_d = STATE_IDLE;
                end else begin
                    beats_d     = beats_q - 4'd1;
                    pkt_d       = '{id: 4'hA, data: {4'h0, next_idx}};
                    pkt_valid_d = 1'b1;
                end
            end
            STATE_WRITE: begin
                if (transfer) begin
                    idle_d = 8'd0;
                    if (in_packet.id == 4'hC) begin
                        pkt_d       = in_packet;
                        pkt_valid_d = 1'b1;
                        if (beats_q == 4'd0) begin
                            state_d = STATE_IDLE;
                        end else begin
                            beats_d = beats_q - 4'd1;
                        end
                    end else begin
                        enter_err = 1'b1;
                    end
                end else if (idle_q == IdleLast) begin
                    enter_err = 1'b1;
                end else begin
                    idle_d = idle_q + 8'd1;
                end
            end
            STATE_ERROR: begin
                if (in_clear) begin
                    state_d = STATE_IDLE;
                end
            end
            default: begin
                state_d = STATE_IDLE;
                beats_d = 4'd0;
                idle_d  = 8'd0;
            end
        endcase

        if (enter_err) begin
            state_d = STATE_ERROR;
            beats_d = 4'd0;
            idle_d  = 8'd0;
            if (err_q != 8'hFF) begin
                err_d = err_q + 8'd1;
            end
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q     <= STATE_IDLE;
            pkt_q       <= '0;
            pkt_valid_q <= 1'b0;
            beats_q     <= 4'd0;
            idle_q      <= 8'd0;
            err_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            pkt_q       <= pkt_d;
            pkt_valid_q <= pkt_valid_d;
            beats_q     <= beats_d;
            idle_q      <= idle_d;
            err_q       <= err_d;
        end
    end

    assign out_state      = state_q;
    assign out_packet     = pkt_q;
    assign out_pkt_valid  = pkt_valid_q;
    assign out_beats_left = beats_q;
    assign out_err_count  = err_q;

endmodule

// File: tb/tb_mod_pkt_fsm_sequencer.sv
// Bench for mod_pkt_fsm_sequencer: directed scenarios with literal expectations, then random
// traffic checked every cycle against a burst-level reference model.
module tb_mod_pkt_fsm_sequencer;

    localparam int TO = 7;

    logic        in_clk;
    logic        in_rst;
    logic        in_valid;
    logic        out_ready;
    logic [11:0] in_packet;
    logic        in_clear;
    fsm_state_e  out_state;
    logic [11:0] out_packet;
    logic        out_pkt_valid;
    logic [3:0]  out_beats_left;
    logic [7:0]  out_err_count;

    mod_pkt_fsm_sequencer #(.TIMEOUT(TO)) dut (
        .in_clk         (in_clk),
        .in_rst         (in_rst),
        .in_valid       (in_valid),
        .out_ready      (out_ready),
        .in_packet      (in_packet),
        .in_clear       (in_clear),
        .out_state      (out_state),
        .out_packet     (out_packet),
        .out_pkt_valid  (out_pkt_valid),
        .out_beats_left (out_beats_left),
        .out_err_count  (out_err_count)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    // Reference model: burst length and beats completed, rather than a down-counter.
    fsm_state_e  m_state;
    int          m_len;
    int          m_done;
    int          m_idle;
    int          m_err;
    logic        m_valid;
    logic [11:0] m_pkt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = STATE_IDLE;
        m_len   = 0;
        m_done  = 0;
        m_idle  = 0;
        m_err   = 0;
        m_valid = 1'b0;
        m_pkt   = 12'h000;
    endtask

    task automatic model_error();
        m_state = STATE_ERROR;
        m_idle  = 0;
        if (m_err < 255) m_err++;
    endtask

    task automatic model_step();
        logic       xfer;
        logic [3:0] id;
        xfer    = in_valid && (m_state == STATE_IDLE || m_state == STATE_WRITE);
        id      = in_packet[11:8];
        m_valid = 1'b0;
        case (m_state)
            STATE_IDLE: begin
                if (xfer) begin
                    if (id == 4'hA) begin
                        m_state = STATE_READ;
                        m_len   = int'(in_packet[3:0]) + 1;
                        m_done  = 0;
                        m_valid = 1'b1;
                        m_pkt   = 12'hA00;
                    end else if (id == 4'hB) begin
                        m_state = STATE_WRITE;
                        m_len   = int'(in_packet[3:0]) + 1;
                        m_done  = 0;
                        m_idle  = 0;
                    end else begin
                        model_error();
                    end
                end
            end
            STATE_READ: begin
                if (m_done == m_len - 1) begin
                    m_state = STATE_IDLE;
                end else begin
                    m_done++;
                    m_valid = 1'b1;
                    m_pkt   = {4'hA, 8'(m_done)};
                end
            end
            STATE_WRITE: begin
                if (xfer) begin
                    m_idle = 0;
                    if (id == 4'hC) begin
                        m_valid = 1'b1;
                        m_pkt   = in_packet;
                        m_done++;
                        if (m_done == m_len) m_state = STATE_IDLE;
                    end else begin
                        model_error();
                    end
                end else begin
                    m_idle++;
                    if (m_idle == TO) model_error();
                end
            end
            default: begin
                if (in_clear) m_state = STATE_IDLE;
            end
        endcase
    endtask

    function automatic logic [31:0] exp_beats();
        if (m_state == STATE_READ || m_state == STATE_WRITE) return 32'(m_len - 1 - m_done);
        return 32'd0;
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge in_clk or posedge in_rst);
            if (in_rst) model_reset();
            else        model_step();
        end
    end

    initial begin
        forever begin
            @(negedge in_clk);
            if (cmp_en) begin
                chk("state", 32'(out_state), 32'(m_state));
                chk("ready", 32'(out_ready),
                    32'(m_state == STATE_IDLE || m_state == STATE_WRITE));
                chk("pkt_valid", 32'(out_pkt_valid), 32'(m_valid));
                if (m_valid || in_rst) chk("packet", 32'(out_packet), 32'(m_pkt));
                chk("beats_left", 32'(out_beats_left), exp_beats());
                chk("err_count", 32'(out_err_count), 32'(m_err));
            end
        end
    end

    task automatic cyc(input logic v, input logic [11:0] p, input logic c);
        in_valid  = v;
        in_packet = p;
        in_clear  = c;
        @(posedge in_clk);
        #1;
    endtask

    task automatic chk_out(input string name, input fsm_state_e st, input logic v,
                           input logic [11:0] p, input logic [3:0] b, input logic [7:0] e);
        chk({name, ".state"}, 32'(out_state), 32'(st));
        chk({name, ".valid"}, 32'(out_pkt_valid), 32'(v));
        if (v) chk({name, ".packet"}, 32'(out_packet), 32'(p));
        chk({name, ".beats"}, 32'(out_beats_left), 32'(b));
        chk({name, ".err"}, 32'(out_err_count), 32'(e));
    endtask

    initial begin
        in_rst    = 1'b1;
        in_valid  = 1'b0;
        in_packet = 12'h000;
        in_clear  = 1'b0;
        repeat (2) @(posedge in_clk);
        #1;
        in_rst = 1'b0;
        cmp_en = 1'b1;
        chk("reset.packet", 32'(out_packet), 32'h000);
        chk_out("reset", STATE_IDLE, 1'b0, 12'h000, 4'd0, 8'd0);

        // READ burst of three beats, header on the first edge after reset release.
        cyc(1'b1, 12'hA02, 1'b0);
        chk_out("rd0", STATE_READ, 1'b1, 12'hA00, 4'd2, 8'd0);
        chk("rd0.ready", 32'(out_ready), 32'd0);
        cyc(1'b0, 12'h000, 1'b0);
        chk_out("rd1", STATE_READ, 1'b1, 12'hA01, 4'd1, 8'd0);
        cyc(1'b0, 12'h000, 1'b0);
        chk_out("rd2", STATE_READ, 1'b1, 12'hA02, 4'd0, 8'd0);
        cyc(1'b0, 12'h000, 1'b0);
        chk_out("rd_end", STATE_IDLE, 1'b0, 12'h000, 4'd0, 8'd0);

        // WRITE burst of two data beats, back to back.
        cyc(1'b1, 12'hB01, 1'b0);
        chk_out("wr_hdr", STATE_WRITE, 1'b0, 12'h000, 4'd1, 8'd0);
        cyc(1'b1, 12'hC55, 1'b0);
        chk_out("wr0", STATE_WRITE, 1'b1, 12'hC55, 4'd0, 8'd0);
        cyc(1'b1, 12'hC66, 1'b0);
        chk_out("wr1", STATE_IDLE, 1'b1, 12'hC66, 4'd0, 8'd0);
        cyc(1'b0, 12'h000, 1'b0);
        chk_out("wr_end", STATE_IDLE, 1'b0, 12'h000, 4'd0, 8'd0);

        // Bad data id inside WRITE.
        cyc(1'b1, 12'hB03, 1'b0);
        chk_out("bad_hdr", STATE_WRITE, 1'b0, 12'h000, 4'd3, 8'd0);
        cyc(1'b1, 12'hD00, 1'b0);
        chk_out("bad_beat", STATE_ERROR, 1'b0, 12'h000, 4'd0, 8'd1);
        chk("bad_beat.ready", 32'(out_ready), 32'd0);
        cyc(1'b0, 12'h000, 1'b1);
        chk_out("bad_clear", STATE_IDLE, 1'b0, 12'h000, 4'd0, 8'd1);

        // Idle timeout boundary, then one cycle short of it.
        cyc(1'b1, 12'hB03, 1'b0);
        repeat (TO - 1) cyc(1'b0, 12'h000, 1'b0);
        chk_out("to_almost", STATE_WRITE, 1'b0, 12'h000, 4'd3, 8'd1);
        cyc(1'b0, 12'h000, 1'b0);
        chk_out("to_hit", STATE_ERROR, 1'b0, 12'h000, 4'd0, 8'd2);
        cyc(1'b0, 12'h000, 1'b1);
        cyc(1'b1, 12'hB03, 1'b0);
        repeat (TO - 1) cyc(1'b0, 12'h000, 1'b0);
        cyc(1'b1, 12'hC11, 1'b0);
        chk_out("to_save", STATE_WRITE, 1'b1, 12'hC11, 4'd2, 8'd2);
        cyc(1'b1, 12'hC22, 1'b0);
        cyc(1'b1, 12'hC33, 1'b0);
        chk_out("to_b2", STATE_WRITE, 1'b1, 12'hC33, 4'd0, 8'd2);
        cyc(1'b1, 12'hC44, 1'b0);
        chk_out("to_end", STATE_IDLE, 1'b1, 12'hC44, 4'd0, 8'd2);

        // Error counter saturation.
        cyc(1'b1, 12'hF00, 1'b0);
        chk_out("sat_first", STATE_ERROR, 1'b0, 12'h000, 4'd0, 8'd3);
        cyc(1'b0, 12'h000, 1'b1);
        for (int i = 1; i < 260; i++) begin
            cyc(1'b1, 12'hF00, 1'b0);
            cyc(1'b0, 12'h000, 1'b1);
        end
        chk_out("sat", STATE_IDLE, 1'b0, 12'h000, 4'd0, 8'd255);

        // Asynchronous reset in the middle of a READ burst.
        cyc(1'b1, 12'hA05, 1'b0);
        cyc(1'b0, 12'h000, 1'b0);
        chk_out("arst_pre", STATE_READ, 1'b1, 12'hA01, 4'd4, 8'd255);
        #2;
        in_rst = 1'b1;
        #1;
        chk("arst.packet", 32'(out_packet), 32'h000);
        chk_out("arst", STATE_IDLE, 1'b0, 12'h000, 4'd0, 8'd0);
        @(posedge in_clk);
        #1;
        in_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 12'h000, 1'b0);
            chk_out("arst_post", STATE_IDLE, 1'b0, 12'h000, 4'd0, 8'd0);
        end

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic [3:0]  id;
            logic [11:0] p;
            int          k;
            k = $urandom_range(0, 9);
            if (k < 2)      id = 4'hA;
            else if (k < 4) id = 4'hB;
            else if (k < 8) id = 4'hC;
            else            id = 4'($urandom_range(0, 15));
            p = {id, 8'($urandom_range(0, 255))};
            if ($urandom_range(0, 399) == 0) begin
                in_rst = 1'b1;
                cyc(1'b0, p, 1'b0);
                in_rst = 1'b0;
            end else if ($urandom_range(0, 39) == 0) begin
                repeat ($urandom_range(TO - 2, TO + 2))
                    cyc(1'b0, p, 1'($urandom_range(0, 1)));
            end else begin
                cyc(1'($urandom_range(0, 9) < 7), p, 1'($urandom_range(0, 3) == 0));
            end
        end

        @(negedge in_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mod_pkt_fsm_sequencer.md
MOD_PKT_FSM_SEQUENCER -- requirements
Module: mod_pkt_fsm_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning idle cycles tolerated inside a WRITE burst before erroring (legal range 1..255).
REQ-002 SHALL have port in_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port in_rst, input, 1, reset; asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, upstream packet valid.
REQ-005 SHALL have port out_ready, output, 1, block accepts in_packet this cycle.
REQ-006 SHALL have port in_packet, input, my_packet_t (12), incoming command/data packet {id[3:0], data[7:0]}.
REQ-007 SHALL have port in_clear, input, 1, error acknowledge.
REQ-008 SHALL have port out_state, output, fsm_state_e, current FSM state, consumed by the downstream action decoder.
REQ-009 SHALL have port out_packet, output, my_packet_t (12), registered outgoing packet.
REQ-010 SHALL have port out_pkt_valid, output, 1, out_packet valid (one-cycle qualifier, no backpressure).
REQ-011 SHALL have port out_beats_left, output, 4, remaining beats in current burst.
REQ-012 SHALL have port out_err_count, output, 8, saturating count of ERROR entries.

Function
REQ-013 SHALL implement states STATE_IDLE, STATE_READ, STATE_WRITE, STATE_ERROR; out_state is the registered state.
REQ-014 Transfer SHALL occur only on a cycle with in_valid && out_ready.
REQ-015 out_ready SHALL be 1 in IDLE and WRITE, 0 in READ and ERROR (combinational from state).
REQ-016 IDLE, transfer with id==4'hA: go READ, beats_left = data[3:0] (burst length data[3:0]+1).
REQ-017 IDLE, transfer with id==4'hB: go WRITE, beats_left = data[3:0]; header not forwarded.
REQ-018 IDLE, transfer with any other id: go ERROR; no transfer: stay IDLE.
REQ-019 READ: every cycle emit out_pkt_valid=1, out_packet={4'hA, 4'h0, beat index}, index 0 at first READ cycle, incrementing; when beats_left==0 on an emitted beat, next state IDLE, else beats_left decrements.
REQ-020 WRITE: each transfer with id==4'hC SHALL be forwarded as out_packet=in_packet with out_pkt_valid=1 on the following cycle (latency 1); beats_left decrements; transfer while beats_left==0 returns to IDLE.
REQ-021 WRITE: transfer with id!=4'hC SHALL go ERROR and SHALL NOT be forwarded.
REQ-022 WRITE: idle counter counts consecutive cycles without transfer, cleared on transfer and on WRITE entry; reaching TIMEOUT SHALL go ERROR.
REQ-023 ERROR: remain until in_clear==1, then IDLE next cycle; in_clear in other states ignored.
REQ-024 Each entry into ERROR SHALL increment out_err_count, saturating at 255 (no wrap).
REQ-025 beats_left SHALL be forced to 0 on entry to ERROR or IDLE.
REQ-026 out_pkt_valid SHALL be 0 in every cycle not specified by REQ-019/REQ-020.
REQ-027 Unreachable state encodings SHALL recover to STATE_IDLE next cycle.

Reset
REQ-028 in_rst asserted SHALL immediately force out_state=STATE_IDLE, out_packet=12'h000, out_pkt_valid=0, out_beats_left=0, out_err_count=0, idle counter=0, regardless of clock.
REQ-029 Reset mid-burst SHALL abandon the burst with no further beats emitted after release.
REQ-030 First transfer SHALL be possible on the first rising edge after in_rst deasserts.

Verification
REQ-031 Reset, then in_packet={A,8'h02} valid one cycle -> READ for 3 cycles, out_packet.data 0,1,2 with out_pkt_valid=1, out_ready=0, then IDLE.
REQ-032 Header {B,8'h01}, then {C,8'h55},{C,8'h66} back-to-back -> out_packet {C,55},{C,66} each one cycle after acceptance, then IDLE, out_err_count=0.
REQ-033 Header {B,8'h03}, beat {D,8'h00} -> ERROR, no forward, out_err_count=1; in_clear pulse -> IDLE next cycle.
REQ-034 Header {B,8'h03} then in_valid=0 for TIMEOUT cycles -> ERROR on that boundary cycle; TIMEOUT-1 idle cycles then a valid C beat -> stays WRITE.
REQ-035 Header {F,8'h00} repeated 260 times with in_clear between -> out_err_count saturates at 255.
REQ-036 Assert in_rst asynchronously mid-READ (between edges) -> all outputs at reset values immediately, no beat after release.
